// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the load/store unit: pointer register pair, default widths
// and the FSM state encoding.
package mem_access_unit_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int REG_AW_DEF = 4;

    // The RAM pointer lives in a fixed register pair: low byte in RM0, high bits in RM0_HI.
    localparam int RM0    = 14;
    localparam int RM0_HI = RM0 + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STORE   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_LOAD_WB = 3'd3,
        ST_INC_LO  = 3'd4,
        ST_INC_HI  = 3'd5
    } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store engine between the control unit and data RAM; owns the register-file
// write port for load results and pointer post-increment.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic              req_inc,
    input  logic [REG_AW-1:0] req_reg,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] ram_ptr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rf_w_enable,
    output logic [REG_AW-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              busy,
    output logic              done
);

    state_e              state_q;
    logic                inc_q;
    logic [REG_AW-1:0]   reg_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic                ram_re_q;
    logic                ram_we_q;
    logic                rf_we_q;
    logic [REG_AW-1:0]   rf_w_addr_q;
    logic [DATA_W-1:0]   rf_w_data_q;
    logic                wb_from_ram_q;
    logic                done_q;
    logic [ADDR_W-1:0]   nptr_d;

    assign nptr_d = ptr_q + ADDR_W'(1);

    // Outputs for the next state are registered alongside the state transition,
    // so every output is a flop except the RAM read data passed through during writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            inc_q         <= 1'b0;
            reg_q         <= '0;
            ptr_q         <= '0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_re_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_w_addr_q   <= '0;
            rf_w_data_q   <= '0;
            wb_from_ram_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            ram_re_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            wb_from_ram_q <= 1'b0;
            done_q        <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        inc_q      <= req_inc;
                        reg_q      <= req_reg;
                        ptr_q      <= ram_ptr;
                        ram_addr_q <= ram_ptr;
                        if (req_store) begin
                            state_q     <= ST_STORE;
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= req_wdata;
                            done_q      <= !req_inc;
                        end else begin
                            state_q  <= ST_LOAD;
                            ram_re_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state_q       <= ST_LOAD_WB;
                    rf_we_q       <= 1'b1;
                    rf_w_addr_q   <= reg_q;
                    wb_from_ram_q <= 1'b1;
                    done_q        <= !inc_q;
                end
                ST_STORE, ST_LOAD_WB: begin
                    if (inc_q) begin
                        state_q     <= ST_INC_LO;
                        rf_we_q     <= 1'b1;
                        rf_w_addr_q <= REG_AW'(RM0);
                        rf_w_data_q <= DATA_W'(nptr_d[7:0]);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_INC_LO: begin
                    // High half is always written, even when the increment did not carry.
                    state_q     <= ST_INC_HI;
                    rf_we_q     <= 1'b1;
                    rf_w_addr_q <= REG_AW'(RM0_HI);
                    rf_w_data_q <= DATA_W'(nptr_d >> 8);
                    done_q      <= 1'b1;
                end
                ST_INC_HI: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_re      = ram_re_q;
    assign ram_we      = ram_we_q;
    assign rf_w_enable = rf_we_q;
    assign rf_w_addr   = rf_w_addr_q;
    assign rf_w_data   = wb_from_ram_q ? ram_rdata : rf_w_data_q;
    assign done        = done_q;

endmodule
